// File: rtl/test_value_uart_monitor.sv
// rtl/test_value_uart_monitor.sv - captures test_value_i changes into a FIFO and prints each as hex text over UART
// Optional macro TEST_MON_CRLF_EN: terminate each entry with CR LF instead of LF alone.
module test_value_uart_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [15:0]                   test_value_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0]   PTR_ONE  = 1;
    localparam logic [CNTW-1:0] CNT_ONE  = 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef TEST_MON_CRLF_EN
    localparam logic [2:0]      LAST_IDX = 3'd5;
`else
    localparam logic [2:0]      LAST_IDX = 3'd4;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       prev_q;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       value_q, value_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        char_q, char_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;

    logic push, pop, full, push_ok, cnt_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_of(input logic [15:0] v, input logic [2:0] idx);
        case (idx)
            3'd0:    return hex_char(v[15:12]);
            3'd1:    return hex_char(v[11:8]);
            3'd2:    return hex_char(v[7:4]);
            3'd3:    return hex_char(v[3:0]);
`ifdef TEST_MON_CRLF_EN
            3'd4:    return 8'h0D;
`endif
            default: return 8'h0A;
        endcase
    endfunction

    // A full FIFO still accepts a push when the transmitter pops on the same edge.
    assign push     = (test_value_i != prev_q);
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign full     = (count_q == CNT_FULL);
    assign push_ok  = push && (!full || pop);
    assign cnt_last = (cnt_q == CLK_LAST);

    always_comb begin
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ovf_d    = ovf_q | (push & ~push_ok);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        idx_d   = idx_q;
        char_d  = char_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    value_d = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                char_d  = char_of(value_q, idx_q);
                cnt_d   = '0;
                bit_d   = 3'd0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = char_q[bit_q];
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            prev_q   <= 16'h0000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            value_q  <= 16'h0000;
            idx_q    <= 3'd0;
            char_q   <= 8'h00;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            prev_q   <= test_value_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            value_q  <= value_d;
            idx_q    <= idx_d;
            char_q   <= char_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= test_value_i;
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != S_IDLE);
    assign fifo_count_o = count_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_test_value_uart_monitor.sv
// tb/tb_test_value_uart_monitor.sv - directed and random checks of test_value_uart_monitor against a queue-level model
module tb_test_value_uart_monitor;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef TEST_MON_CRLF_EN
    localparam int NCH = 6;
`else
    localparam int NCH = 5;
`endif
    localparam int ENTRY_CYCLES = NCH * (1 + 10 * CPB);

    logic        clk;
    logic        reset_n;
    logic [15:0] test_value_i;
    logic        tx_o;
    logic        busy_o;
    logic [3:0]  fifo_count_o;
    logic        overflow_o;

    test_value_uart_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .test_value_i (test_value_i),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mq [$];
    logic [7:0]  expq [$];
    logic [7:0]  rxq [$];
    logic [15:0] mprev;
    logic        movf;
    longint      ecnt = 0;
    longint      idle_from = 0;
    int          busy_edges = 0;
    bit          tx_low_seen = 0;
    int          frame_errs = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART receiver, fixed to CPB clocks per bit; aborts on reset.
    initial begin : decoder
        int dcnt;
        logic [7:0] dsh;
        dcnt = -1;
        dsh  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                dcnt = -1;
            end else if (dcnt < 0) begin
                if (tx_o === 1'b0) dcnt = 0;
            end else begin
                dcnt++;
                if (dcnt >= 5 && dcnt <= 33 && ((dcnt - 5) % 4) == 0)
                    dsh[(dcnt - 5) / 4] = tx_o;
                if (dcnt == 37) begin
                    if (tx_o === 1'b1) rxq.push_back(dsh);
                    else               frame_errs++;
                    dcnt = -1;
                end
            end
        end
    end

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    task automatic model_reset();
        mq.delete();
        expq.delete();
        rxq.delete();
        mprev     = 16'h0000;
        movf      = 1'b0;
        idle_from = ecnt;
    endtask

    // One clock edge with input v; the model decides pop, push and drop from queue occupancy and transmitter timing.
    task automatic tick(input logic [15:0] v);
        logic [15:0] h;
        test_value_i = v;
        @(posedge clk);
        ecnt++;
        if (mq.size() > 0 && ecnt >= idle_from) begin
            h = mq.pop_front();
            for (int k = 3; k >= 0; k--) expq.push_back(hexc((h >> (4 * k)) % 16));
`ifdef TEST_MON_CRLF_EN
            expq.push_back(8'h0D);
`endif
            expq.push_back(8'h0A);
            idle_from = ecnt + ENTRY_CYCLES + 1;
        end
        if (v != mprev) begin
            if (mq.size() < DEPTH) mq.push_back(v);
            else                   movf = 1'b1;
            mprev = v;
        end
        #1;
        if (busy_o === 1'b1) busy_edges++;
        if (tx_o !== 1'b1) tx_low_seen = 1;
        chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
        chk("overflow", 32'(overflow_o), 32'(movf));
    endtask

    task automatic drain(input logic [15:0] v);
        int n;
        n = 0;
        while ((mq.size() > 0 || ecnt < idle_from + 10) && n < 20000) begin
            tick(v);
            n++;
        end
        chk("drain_within_budget", 32'(n < 20000), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 32'(rxq.size()), 32'(expq.size()));
        for (int i = 0; i < rxq.size() && i < expq.size(); i++)
            chk({tag, "_byte"}, 32'(rxq[i]), 32'(expq[i]));
        rxq.delete();
        expq.delete();
    endtask

    initial begin : main
        int n;
        logic [15:0] v;
        reset_n      = 1'b0;
        test_value_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;

        // Outputs pinned while reset is held and the input toggles.
        for (int i = 0; i < 30; i++) begin
            test_value_i = 16'($urandom);
            @(posedge clk);
            #1;
            chk("rst_tx", 32'(tx_o), 32'd1);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_count", 32'(fifo_count_o), 32'd0);
            chk("rst_ovf", 32'(overflow_o), 32'd0);
        end
        test_value_i = 16'h0000;
        reset_n      = 1'b1;
        model_reset();

        // Constant zero after reset: nothing captured, line idle.
        tx_low_seen = 0;
        repeat (500) tick(16'h0000);
        chk("quiet_tx_low_seen", 32'(tx_low_seen), 32'd0);
        chk("quiet_rx_bytes", 32'(rxq.size()), 32'd0);

        // Single change: start bit exactly three edges later, full busy window.
        busy_edges = 0;
        tick(16'h1A2F);
        tick(16'h1A2F);
        chk("lat_n1_tx", 32'(tx_o), 32'd1);
        tick(16'h1A2F);
        chk("lat_n2_tx", 32'(tx_o), 32'd1);
        tick(16'h1A2F);
        chk("lat_n3_tx", 32'(tx_o), 32'd0);
        drain(16'h1A2F);
        chk("busy_cycles", 32'(busy_edges), 32'(ENTRY_CYCLES));
        if (rxq.size() >= 5) begin
            chk("hex_1a2f_0", 32'(rxq[0]), 32'h31);
            chk("hex_1a2f_1", 32'(rxq[1]), 32'h41);
            chk("hex_1a2f_2", 32'(rxq[2]), 32'h32);
            chk("hex_1a2f_3", 32'(rxq[3]), 32'h46);
        end
        compare_stream("single");

        // Ten changes on consecutive edges: one popped, eight queued, tenth dropped.
        for (int i = 1; i <= 10; i++) tick(16'h5A00 + 16'(i * 17));
        chk("burst_count", 32'(fifo_count_o), 32'd8);
        chk("burst_ovf", 32'(overflow_o), 32'd1);
        drain(16'h5A00 + 16'(10 * 17));
        compare_stream("burst");

        // Reset in the middle of the second character's data bits.
        reset_n = 1'b0;
        test_value_i = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        tick(16'hBEEF);
        n = 0;
        while (rxq.size() < 1 && n < 200) begin
            tick(16'hBEEF);
            n++;
        end
        chk("midframe_first_char_seen", 32'(n < 200), 32'd1);
        repeat (15) tick(16'hBEEF);
        reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_count", 32'(fifo_count_o), 32'd0);
        test_value_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("midrst_rx_bytes", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("midrst_first_byte", 32'(rxq[0]), 32'h42);
        model_reset();
        tx_low_seen = 0;
        repeat (300) tick(16'h0000);
        chk("post_rst_tx_low_seen", 32'(tx_low_seen), 32'd0);
        chk("post_rst_rx_bytes", 32'(rxq.size()), 32'd0);

        // Nonzero input across reset release is captured on the first edge.
        reset_n = 1'b0;
        test_value_i = 16'h00FF;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        tick(16'h00FF);
        chk("first_edge_capture", 32'(fifo_count_o), 32'd1);
        drain(16'h00FF);
        compare_stream("first_edge");

        // Random values with a mix of single-cycle bursts and long holds.
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 7) == 0) ? mprev : 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : 1;
            repeat (n) tick(v);
        end
        drain(mprev);
        compare_stream("random");

        chk("framing_errors", 32'(frame_errs), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
